// File: rtl/sockit_spi_pkg.sv
// Shared types and helpers for the SPI command-stream arbiter.
package sockit_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_st_t;

    // Round-robin winner: a lone requester wins, a tie goes to the one that is not pri.
    function automatic logic rr_win(input logic req0, input logic req1, input logic pri);
        if (req0 && req1) begin
            return ~pri;
        end
        return req1;
    endfunction

endpackage

// File: rtl/sockit_spi_mux.sv
// Data/handshake steering from the granted requester onto the shared command stream.
module sockit_spi_mux
    import sockit_spi_pkg::*;
#(
    parameter type DT = logic [31:0]
) (
    input  logic sel,
    input  logic gnt,
    input  logic si0_vld,
    input  DT    si0_dat,
    output logic si0_rdy,
    input  logic si1_vld,
    input  DT    si1_dat,
    output logic si1_rdy,
    output logic sto_vld,
    output DT    sto_dat,
    input  logic sto_rdy
);

    assign sto_vld = gnt & (sel ? si1_vld : si0_vld);
    assign sto_dat = gnt ? (sel ? si1_dat : si0_dat) : '0;
    assign si0_rdy = gnt & ~sel & sto_rdy;
    assign si1_rdy = gnt &  sel & sto_rdy;

endmodule

// File: rtl/sockit_spi_arb.sv
// Packet-level round-robin arbiter sharing one SPI command stream between two sources.
//
//   state | meaning
//   IDLE  | no grant, all stream outputs quiet
//   G0    | si0 owns the output stream until its lst beat or timeout
//   G1    | si1 owns the output stream until its lst beat or timeout
module sockit_spi_arb
    import sockit_spi_pkg::*;
#(
    parameter type DT  = logic [31:0],
    parameter int  TMO = 16,
    localparam int TW  = (TMO > 0) ? $clog2(TMO + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic si0_vld,
    input  DT    si0_dat,
    output logic si0_rdy,
    input  logic si0_lst,
    input  logic si1_vld,
    input  DT    si1_dat,
    output logic si1_rdy,
    input  logic si1_lst,
    output logic sto_vld,
    output DT    sto_dat,
    input  logic sto_rdy,
    output logic sto_lst,
    output logic sel,
    output logic gnt,
    output logic err
);

    arb_st_t       st;
    logic          pri;
    logic [TW-1:0] tmo_cnt;

    logic g_vld;
    logic g_lst;
    logic g_end;
    logic req0;
    logic req1;
    logic win;

    assign g_vld   = sel ? si1_vld : si0_vld;
    assign g_lst   = sel ? si1_lst : si0_lst;
    assign g_end   = gnt & g_vld & sto_rdy & g_lst;
    assign sto_lst = gnt & g_lst;

    // The granted side's vld on its lst beat belongs to the finished packet, not a new request.
    assign req0 = si0_vld & ~(g_end & ~sel);
    assign req1 = si1_vld & ~(g_end &  sel);
    assign win  = rr_win(req0, req1, pri);

    sockit_spi_mux #(.DT(DT)) u_mux (
        .sel     (sel),
        .gnt     (gnt),
        .si0_vld (si0_vld),
        .si0_dat (si0_dat),
        .si0_rdy (si0_rdy),
        .si1_vld (si1_vld),
        .si1_dat (si1_dat),
        .si1_rdy (si1_rdy),
        .sto_vld (sto_vld),
        .sto_dat (sto_dat),
        .sto_rdy (sto_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            sel     <= 1'b0;
            gnt     <= 1'b0;
            pri     <= 1'b1;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (req0 | req1) begin
                        st      <= win ? G1 : G0;
                        sel     <= win;
                        gnt     <= 1'b1;
                        pri     <= win;
                        tmo_cnt <= '0;
                    end
                end
                G0, G1: begin
                    if (g_end) begin
                        tmo_cnt <= '0;
                        if (req0 | req1) begin
                            st  <= win ? G1 : G0;
                            sel <= win;
                            pri <= win;
                        end else begin
                            st  <= IDLE;
                            gnt <= 1'b0;
                        end
                    end else if (g_vld) begin
                        tmo_cnt <= '0;
                    end else if (TMO > 0) begin
                        if (tmo_cnt == TW'(TMO - 1)) begin
                            // Stalled source: revoke and hand the next tie to the other side.
                            st      <= IDLE;
                            gnt     <= 1'b0;
                            err     <= 1'b1;
                            pri     <= sel;
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    st  <= IDLE;
                    gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Directed-vector bench for the SPI command-stream arbiter (timeout limit 4).
module tb_sockit_spi_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        si0_vld = 1'b0, si0_lst = 1'b0, si0_rdy;
    logic [31:0] si0_dat = '0;
    logic        si1_vld = 1'b0, si1_lst = 1'b0, si1_rdy;
    logic [31:0] si1_dat = '0;
    logic        sto_vld, sto_lst, sto_rdy = 1'b0;
    logic [31:0] sto_dat;
    logic        sel, gnt, err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sockit_spi_arb #(.TMO(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .si0_vld (si0_vld),
        .si0_dat (si0_dat),
        .si0_rdy (si0_rdy),
        .si0_lst (si0_lst),
        .si1_vld (si1_vld),
        .si1_dat (si1_dat),
        .si1_rdy (si1_rdy),
        .si1_lst (si1_lst),
        .sto_vld (sto_vld),
        .sto_dat (sto_dat),
        .sto_rdy (sto_rdy),
        .sto_lst (sto_lst),
        .sel     (sel),
        .gnt     (gnt),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        si0_vld = 1'b0; si0_lst = 1'b0; si0_dat = '0;
        si1_vld = 1'b0; si1_lst = 1'b0; si1_dat = '0;
        sto_rdy = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        #1;
        chk("rst_gnt", {31'd0, gnt}, 0);
        chk("rst_sel", {31'd0, sel}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_sto_vld", {31'd0, sto_vld}, 0);
        chk("rst_rdy", {30'd0, si0_rdy, si1_rdy}, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int c;

        // Single requester, 3-beat packet
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'h11; sto_rdy = 1'b1;
        #1;
        chk("t1_idle_gnt", {31'd0, gnt}, 0);
        chk("t1_idle_vld", {31'd0, sto_vld}, 0);
        tick();
        chk("t1_gnt", {31'd0, gnt}, 1);
        chk("t1_b1", sto_dat, 32'h11);
        chk("t1_rdy0", {31'd0, si0_rdy}, 1);
        tick();
        si0_dat = 32'h22;
        #1;
        chk("t1_b2", sto_dat, 32'h22);
        chk("t1_b2_vld", {31'd0, sto_vld}, 1);
        tick();
        si0_dat = 32'h33; si0_lst = 1'b1;
        #1;
        chk("t1_b3", sto_dat, 32'h33);
        chk("t1_b3_lst", {31'd0, sto_lst}, 1);
        tick();
        si0_vld = 1'b0; si0_lst = 1'b0;
        #1;
        chk("t1_end_gnt", {31'd0, gnt}, 0);
        chk("t1_end_vld", {31'd0, sto_vld}, 0);

        // Contention from reset: si0 first, zero-bubble handoff to si1, next tie to si0
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'hA0;
        si1_vld = 1'b1; si1_dat = 32'hB0; si1_lst = 1'b1;
        sto_rdy = 1'b1;
        tick();
        chk("t2_sel0", {31'd0, sel}, 0);
        chk("t2_dat_a0", sto_dat, 32'hA0);
        chk("t2_rdy1_0", {31'd0, si1_rdy}, 0);
        tick();
        si0_dat = 32'hA1; si0_lst = 1'b1;
        #1;
        chk("t2_dat_a1", sto_dat, 32'hA1);
        tick();
        si0_vld = 1'b0; si0_lst = 1'b0;
        #1;
        chk("t2_handoff_gnt", {31'd0, gnt}, 1);
        chk("t2_handoff_sel", {31'd0, sel}, 1);
        chk("t2_dat_b0", sto_dat, 32'hB0);
        chk("t2_rdy0_0", {31'd0, si0_rdy}, 0);
        tick();
        si1_vld = 1'b0; si1_lst = 1'b0;
        #1;
        chk("t2_idle", {31'd0, gnt}, 0);
        si0_vld = 1'b1; si0_dat = 32'hC0; si0_lst = 1'b1;
        si1_vld = 1'b1; si1_dat = 32'hD0; si1_lst = 1'b1;
        tick();
        chk("t2_tie2_sel", {31'd0, sel}, 0);
        chk("t2_tie2_dat", sto_dat, 32'hC0);
        tick();
        si0_vld = 1'b0;
        #1;
        chk("t2_tie2_next", {31'd0, sel}, 1);

        // Packet integrity: si1 waits for si0's lst under toggling backpressure
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'h40; sto_rdy = 1'b1;
        tick();
        b = 0;
        c = 0;
        while (b < 4 && c < 20) begin
            si0_dat = 32'h40 + b;
            si0_lst = (b == 3);
            sto_rdy = (c % 2 == 0);
            si1_vld = (c > 0);
            si1_dat = 32'hE0;
            #1;
            chk("t3_sel", {31'd0, sel}, 0);
            chk("t3_rdy1", {31'd0, si1_rdy}, 0);
            chk("t3_dat", sto_dat, 32'h40 + b);
            if (sto_rdy) b++;
            c++;
            tick();
        end
        chk("t3_beats", b, 4);
        si0_vld = 1'b0; si0_lst = 1'b0; sto_rdy = 1'b1;
        #1;
        chk("t3_g1_sel", {31'd0, sel}, 1);
        chk("t3_g1_dat", sto_dat, 32'hE0);
        chk("t3_g1_rdy", {31'd0, si1_rdy}, 1);

        // Timeout: si0 stalls after one beat, si1 pending
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'h55; sto_rdy = 1'b1;
        tick();
        chk("t4_gnt", {31'd0, gnt}, 1);
        tick();
        si0_vld = 1'b0; si1_vld = 1'b1; si1_dat = 32'h66;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t4_hold_gnt", {31'd0, gnt}, 1);
            chk("t4_hold_err", {31'd0, err}, 0);
            chk("t4_hold_rdy1", {31'd0, si1_rdy}, 0);
        end
        tick();
        chk("t4_revoke_gnt", {31'd0, gnt}, 0);
        chk("t4_err", {31'd0, err}, 1);
        tick();
        chk("t4_err_clr", {31'd0, err}, 0);
        chk("t4_next_sel", {31'd0, sel}, 1);
        chk("t4_next_gnt", {31'd0, gnt}, 1);
        chk("t4_next_dat", sto_dat, 32'h66);

        // Backpressure never advances the timeout
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'h77; sto_rdy = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_gnt", {31'd0, gnt}, 1);
            chk("t5_err", {31'd0, err}, 0);
            chk("t5_dat", sto_dat, 32'h77);
            chk("t5_rdy0", {31'd0, si0_rdy}, 0);
            tick();
        end

        // Async reset during beat 2
        do_reset();
        si0_vld = 1'b1; si0_dat = 32'h61; sto_rdy = 1'b1;
        tick();
        tick();
        si0_dat = 32'h62;
        #1;
        chk("t6_b2", sto_dat, 32'h62);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_gnt", {31'd0, gnt}, 0);
        chk("t6_vld", {31'd0, sto_vld}, 0);
        chk("t6_rdy", {30'd0, si0_rdy, si1_rdy}, 0);
        chk("t6_dat", sto_dat, 0);
        tick();
        rst = 1'b0;
        si1_vld = 1'b1; si1_dat = 32'h70;
        tick();
        chk("t6_tie_sel", {31'd0, sel}, 0);
        chk("t6_tie_gnt", {31'd0, gnt}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
